// File: rtl/pgd_pkg.sv
// pgd_pkg: shared state encoding, counter width and default gap timing for the pulse-gap decoder.
package pgd_pkg;
    localparam int CNT_W        = 4;
    localparam int DEF_GAP_ONE  = 3;
    localparam int DEF_GAP_ZERO = 4;
    localparam int DEF_TIMEOUT  = 8;
    localparam int DEF_LOCK_CNT = 2;
    typedef enum logic {HUNT, TRACK} state_t;
endpackage

// File: rtl/pulse_gap_decoder_if.sv
// pulse_gap_decoder_if: pulse stream in, decoded bit/byte strobes out.
interface pulse_gap_decoder_if;
    logic       y_in;
    logic       bit_out;
    logic       bit_valid;
    logic       err;
    logic       locked;
    logic [7:0] byte_out;
    logic       byte_valid;
    modport master (output y_in, input bit_out, bit_valid, err, locked, byte_out, byte_valid);
    modport slave  (input y_in, output bit_out, bit_valid, err, locked, byte_out, byte_valid);
endinterface

// File: rtl/pgd_deser.sv
// pgd_deser: MSB-first 8-bit deserializer of decoded bits; only compiled with PGD_DESER_EN.
`ifdef PGD_DESER_EN
module pgd_deser (
    input  logic       clk,
    input  logic       reset,
    input  logic       shift,
    input  logic       din,
    input  logic       clear,
    output logic [7:0] byte_out,
    output logic       byte_valid
);
    logic [2:0] idx;
    logic [6:0] sh;
    // Inputs are next-cycle strobes, so the byte strobe lines up with the eighth bit_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            sh         <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= shift && &idx;
            if (clear) idx <= '0;
            else if (shift) begin
                sh  <= {sh[5:0], din};
                idx <= idx + 1'b1;
                if (&idx) byte_out <= {sh, din};
            end
        end
    end
endmodule
`endif

// File: rtl/pulse_gap_decoder.sv
// pulse_gap_decoder: decodes bits from pulse-to-pulse gaps on y_in, tracks lock and flags bad gaps/timeouts.
// Define PGD_DESER_EN to add the MSB-first byte deserializer.
module pulse_gap_decoder
    import pgd_pkg::*;
#(
    parameter int GAP_ONE  = DEF_GAP_ONE,
    parameter int GAP_ZERO = DEF_GAP_ZERO,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int LOCK_CNT = DEF_LOCK_CNT
) (
    input logic                clk,
    input logic                reset,
    pulse_gap_decoder_if.slave bus
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [GW-1:0]    good, good_n;
    logic             good_gap, bv_n, err_n, bit_n;
    logic [7:0]       byte_q;
    logic             byte_v;
    always_comb begin
        cnt_n    = bus.y_in ? CNT_W'(1) : cnt + CNT_W'(!(&cnt));
        good_gap = cnt == CNT_W'(GAP_ONE) || cnt == CNT_W'(GAP_ZERO);
        bv_n     = state == TRACK && bus.y_in && good_gap;
        err_n    = state == TRACK && (bus.y_in ? !good_gap : cnt == CNT_W'(TIMEOUT));
        bit_n    = bv_n ? cnt == CNT_W'(GAP_ONE) : bus.bit_out;
        state_n  = bus.y_in ? TRACK : (err_n ? HUNT : state);
        good_n   = (err_n || state_n == HUNT) ? '0 :
                   (bv_n && good != GW'(LOCK_CNT)) ? good + 1'b1 : good;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= HUNT;
            cnt           <= '0;
            good          <= '0;
            bus.bit_out   <= 1'b0;
            bus.bit_valid <= 1'b0;
            bus.err       <= 1'b0;
            bus.locked    <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            good          <= good_n;
            bus.bit_out   <= bit_n;
            bus.bit_valid <= bv_n;
            bus.err       <= err_n;
            bus.locked    <= good_n == GW'(LOCK_CNT);
        end
    end
`ifdef PGD_DESER_EN
    pgd_deser u_deser (
        .clk        (clk),
        .reset      (reset),
        .shift      (bv_n),
        .din        (bit_n),
        .clear      (err_n),
        .byte_out   (byte_q),
        .byte_valid (byte_v)
    );
`else
    assign byte_q = '0;
    assign byte_v = 1'b0;
`endif
    assign bus.byte_out   = byte_q;
    assign bus.byte_valid = byte_v;
endmodule

// File: tb/tb_pulse_gap_decoder.sv
// tb_pulse_gap_decoder: directed pulse-gap vectors; expected strobes queued at stimulus, checked by a monitor.
module tb_pulse_gap_decoder;
    localparam bit DESER =
`ifdef PGD_DESER_EN
        1'b1;
`else
        1'b0;
`endif
    typedef struct {
        int         kind;
        logic       b;
        logic       lk;
        logic       bv;
        logic [7:0] by;
        int         at;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   nvec = 0;
    int   nfail = 0;
    exp_t q[$];
    pulse_gap_decoder_if bus ();
    pulse_gap_decoder dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask
    // kind: -1 no strobe, 0 bit, 1 err
    task automatic send(int gap, int kind, logic b, logic lk, logic bv = 1'b0, logic [7:0] by = 8'h00);
        repeat (gap - 1) begin
            @(negedge clk);
            bus.y_in = 1'b0;
        end
        @(negedge clk);
        bus.y_in = 1'b1;
        if (kind >= 0) q.push_back('{kind, b, lk, bv, by, cyc + 1});
    endtask
    task automatic idle(int n, bit exp_err);
        if (exp_err) q.push_back('{1, 1'b0, 1'b0, 1'b0, 8'h00, cyc + 9});
        repeat (n) begin
            @(negedge clk);
            bus.y_in = 1'b0;
        end
    endtask
    task automatic chk_all_zero(string nm);
        chk({nm, "_outputs"}, {bus.bit_out, bus.bit_valid, bus.err, bus.locked, bus.byte_valid}, 0);
        chk({nm, "_byte_out"}, bus.byte_out, 0);
    endtask
    always @(negedge clk) begin
        if (!reset && (bus.bit_valid || bus.err || bus.byte_valid)) begin
            if (q.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL unexpected_strobe: bit_valid=%b err=%b byte_valid=%b, expected none (cycle %0d)",
                         bus.bit_valid, bus.err, bus.byte_valid, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("strobe_kind", {bus.bit_valid, bus.err}, e.kind == 1 ? 2'b01 : 2'b10);
                chk("strobe_cycle", cyc, e.at);
                chk("locked", bus.locked, e.lk);
                chk("byte_valid", bus.byte_valid, e.bv);
                if (e.kind == 0) chk("bit_out", bus.bit_out, e.b);
                if (e.bv) chk("byte_out", bus.byte_out, e.by);
            end
        end
    end
    initial begin
        bus.y_in = 1'b0;
        #3;
        chk_all_zero("reset");
        #7 reset = 1'b0;
        send(2, -1, 0, 0);
        send(3, 0, 1, 0);
        send(3, 0, 1, 1);
        send(3, 0, 1, 1);
        send(4, 0, 0, 1);
        send(4, 0, 0, 1);
        send(4, 0, 0, 1);
        send(5, 1, 0, 0);
        send(3, 0, 1, 0);
        send(3, 0, 1, 1);
        send(1, 1, 0, 0);
        send(4, 0, 0, 0);
        idle(10, 1);
        send(2, -1, 0, 0);
        send(3, 0, 1, 0);
        send(3, 0, 1, 1);
        idle(2, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_all_zero("mid_gap_reset");
        @(negedge clk);
        reset = 1'b0;
        send(2, -1, 0, 0);
        send(3, 0, 1, 0);
        send(6, 1, 0, 0);
        send(3, 0, 1, 0);
        send(4, 0, 0, 1);
        send(3, 0, 1, 1);
        send(3, 0, 1, 1);
        send(4, 0, 0, 1);
        send(4, 0, 0, 1);
        send(3, 0, 1, 1);
        send(4, 0, 0, 1, DESER, DESER ? 8'hB2 : 8'h00);
        idle(12, 1);
        chk("pending_expectations", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/pulse_gap_decoder.md
PULSE_GAP_DECODER -- requirements
Module: pulse_gap_decoder

Interface
REQ-001 Parameter GAP_ONE, default 3: pulse-to-pulse gap in clock edges that decodes as bit 1.
REQ-002 Parameter GAP_ZERO, default 4: pulse-to-pulse gap in clock edges that decodes as bit 0.
REQ-003 Parameter TIMEOUT, default 8: gap count at which loss of signal is declared; must exceed GAP_ZERO.
REQ-004 Parameter LOCK_CNT, default 2: number of consecutive good gaps required to assert locked.
REQ-005 clk  input  1  clock; all state is updated on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 y_in  input  1  pulse stream from the gap-encoding Moore FSM, synchronous to clk.
REQ-008 bit_out  output  1  decoded bit; meaningful only while bit_valid is high.
REQ-009 bit_valid  output  1  single-cycle strobe marking a decoded bit.
REQ-010 err  output  1  single-cycle strobe on a bad gap or a timeout.
REQ-011 locked  output  1  level; high while the stream is being tracked and recent gaps are good.
REQ-012 byte_out  output  8  assembled byte (see Configuration).
REQ-013 byte_valid  output  1  single-cycle strobe marking an assembled byte (see Configuration).

Function
REQ-014 FSM states: HUNT (no reference pulse yet) and TRACK (measuring the gap since the last pulse).
REQ-015 Gap counter cnt is 4 bits wide, saturating at 15.
REQ-016 On any edge where y_in=1, cnt loads 1; otherwise cnt increments by 1.
REQ-017 The gap of a pulse is the value of cnt at the edge where that pulse is sampled.
REQ-018 HUNT + y_in=1: go to TRACK; produce no bit and no error.
REQ-019 TRACK + y_in=1 with gap==GAP_ONE: register bit_out=1 and assert bit_valid for one cycle.
REQ-020 TRACK + y_in=1 with gap==GAP_ZERO: register bit_out=0 and assert bit_valid for one cycle.
REQ-021 TRACK + y_in=1 with any other gap (including 1, i.e. y_in held high): assert err for one cycle and stay in TRACK, with the new pulse as the reference.
REQ-022 TRACK + y_in=0 with cnt reaching TIMEOUT: assert err for one cycle and go to HUNT.
REQ-023 err is asserted exactly once per timeout.
REQ-024 All outputs are registered; each strobe is high during the cycle immediately after the deciding edge.
REQ-025 bit_valid and err are mutually exclusive.
REQ-026 A good-gap counter increments on each bit_valid event and saturates at LOCK_CNT.
REQ-027 locked=1 when the good-gap counter equals LOCK_CNT.
REQ-028 The good-gap counter clears on err and on entry to HUNT; locked deasserts in the same cycle as err.
REQ-029 bit_out holds its last value between strobes.

Reset
REQ-030 Reset immediately forces: state=HUNT, cnt=0, good-gap counter=0, and outputs bit_out, bit_valid, err, locked, byte_out, byte_valid all 0.
REQ-031 Reset asserted mid-gap discards the partial gap; decoding after release restarts from HUNT.

Configuration
REQ-032 Macro PGD_DESER_EN controls the byte deserializer.
REQ-033 With PGD_DESER_EN defined: each decoded bit shifts into an 8-bit register, MSB first.
REQ-034 With PGD_DESER_EN defined: the eighth bit updates byte_out and pulses byte_valid in the same cycle as that bit's bit_valid.
REQ-035 With PGD_DESER_EN defined: err, and any reset, clear the bit index to 0.
REQ-036 With PGD_DESER_EN not defined: byte_out and byte_valid are tied to 0, and no deserializer logic exists.

Structure
REQ-037 Shared package pgd_pkg holds the state enum (HUNT, TRACK), CNT_W=4, and the default GAP_ONE/GAP_ZERO/TIMEOUT constants.
REQ-038 The deserializer is a sub-module pgd_deser, instantiated only under PGD_DESER_EN.

Verification
REQ-039 Scenario 1: reset high for 10 ns then released; first pulse, then pulses 3 edges apart -> first pulse gives no strobe; then bit_valid with bit_out=1 on each later pulse; locked=1 after the 2nd good gap.
REQ-040 Scenario 2: after lock, pulses 4 edges apart -> bit_valid with bit_out=0 each time; locked stays 1.
REQ-041 Scenario 3: gap of 5, then gap of 3 -> err for one cycle and locked=0; next pulse gives bit_valid with bit_out=1; locked stays 0 until a 2nd good gap.
REQ-042 Scenario 4: y_in held at 0 for 10 cycles while in TRACK -> exactly one err at cnt=8; state returns to HUNT; the next pulse produces no strobe.
REQ-043 Scenario 5: reset asserted 2 edges into a gap -> all outputs 0 immediately; first pulse after release produces no strobe.
REQ-044 Scenario 6 (PGD_DESER_EN defined): gap sequence 3,4,3,3,4,4,3,4 -> byte_valid with byte_out=8'hB2 on the 8th bit; without the macro, byte_valid stays 0.
